// File: rtl/booth_mul_sequencer_pkg.sv
// booth_mul_sequencer_pkg: shared types and constants for the radix-4 Booth multiplier.
// Contents:
//   state_t     - sequencer states IDLE/RUN/DONE
//   digit_sel_t - recoded digit selection ZERO/POS1/POS2/NEG1/NEG2
//   DEF_WIDTH, DEF_STEPS, DEF_CNT_W - default operand width, digit count, step counter width
//   steps_for/cnt_w_for - derive digit count and counter width from an operand width
//   decode_digit - maps {Q[1], Q[0], lookback} to a digit selection
package booth_mul_sequencer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_sel_t;

    function automatic int steps_for(input int w);
        return w / 2;
    endfunction

    function automatic int cnt_w_for(input int w);
        return $clog2(w / 2);
    endfunction

    localparam int DEF_WIDTH = 32;
    localparam int DEF_STEPS = steps_for(DEF_WIDTH);
    localparam int DEF_CNT_W = cnt_w_for(DEF_WIDTH);

    function automatic digit_sel_t decode_digit(input logic [2:0] d);
        return (d == 3'b001 || d == 3'b010) ? POS1 :
               (d == 3'b011)                ? POS2 :
               (d == 3'b100)                ? NEG2 :
               (d == 3'b101 || d == 3'b110) ? NEG1 : ZERO;
    endfunction

endpackage

// File: rtl/booth_pp_select.sv
// booth_pp_select: combinational radix-4 Booth partial-product selector.
// Ports:
//   digit in  [2:0]       {Q[1], Q[0], lookback}
//   m     in  [WIDTH-1:0] signed multiplicand
//   pp    out [WIDTH+1:0] signed partial product in {0, +M, +2M, -M, -2M}
module booth_pp_select
    import booth_mul_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]       digit,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH+1:0] pp
);

    // Two guard bits keep +-2M of the most negative M representable.
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] m_dbl;
    digit_sel_t       sel;

    always_comb begin
        m_ext = {{2{m[WIDTH-1]}}, m};
        m_dbl = m_ext << 1;
        sel   = decode_digit(digit);
        pp    = (sel == POS1) ? m_ext  :
                (sel == POS2) ? m_dbl  :
                (sel == NEG1) ? -m_ext :
                (sel == NEG2) ? -m_dbl : '0;
    end

endmodule

// File: rtl/booth_mul_sequencer.sv
// booth_mul_sequencer: sequential signed radix-4 Booth multiplier, one digit per clock.
// Ports:
//   clk          in  rising-edge clock
//   rst_n        in  asynchronous active-low reset
//   start        in  request, sampled only while not busy
//   flush        in  synchronous abort of an in-flight multiply
//   multiplicand in  [WIDTH-1:0] signed M, sampled with start
//   multiplier   in  [WIDTH-1:0] signed Q, sampled with start
//   busy         out high while running
//   done         out one-cycle pulse, product valid
//   product      out [2*WIDTH-1:0] signed M*Q, held until the next completion
// Optional: define BOOTH_EARLY_EXIT_EN to finish as soon as all remaining digits are zero.
module booth_mul_sequencer
    import booth_mul_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int STEPS = steps_for(WIDTH);
    localparam int CNT_W = cnt_w_for(WIDTH);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   m, q, q_shift;
    logic               lookback;
    logic [CNT_W-1:0]   step;
    logic [2*WIDTH-1:0] acc, acc_next, pp_ext;
    logic [WIDTH+1:0]   pp;
    logic               early, finish;

    booth_pp_select #(.WIDTH(WIDTH)) u_pp (
        .digit ({q[1:0], lookback}),
        .m     (m),
        .pp    (pp)
    );

    assign pp_ext   = {{(WIDTH-2){pp[WIDTH+1]}}, pp};
    assign acc_next = acc + (pp_ext << {step, 1'b0});
    assign q_shift  = $signed(q) >>> 2;

`ifdef BOOTH_EARLY_EXIT_EN
    // Remaining Q bits and the new lookback all equal: every later digit is zero.
    assign early = (&q_shift & q[1]) | ~(|q_shift | q[1]);
`else
    assign early = 1'b0;
`endif

    assign finish = early | (step == CNT_W'(STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // flush outranks completion while running.
    always_comb begin
        state_nxt = (state == RUN) ? (flush ? IDLE : finish ? DONE : RUN) :
                    (start ? RUN : IDLE);
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m        <= '0;
            q        <= '0;
            lookback <= 1'b0;
            step     <= '0;
            acc      <= '0;
            product  <= '0;
        end else if (state != RUN) begin
            if (start) begin
                m        <= multiplicand;
                q        <= multiplier;
                lookback <= 1'b0;
                step     <= '0;
                acc      <= '0;
            end
        end else if (!flush) begin
            acc      <= acc_next;
            q        <= q_shift;
            lookback <= q[1];
            step     <= step + 1'b1;
            if (finish) product <= acc_next;
        end
    end

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// tb_booth_mul_sequencer: scoreboard-driven bench for booth_mul_sequencer (WIDTH=32).
// Honors BOOTH_EARLY_EXIT_EN when predicting latency.
module tb_booth_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        busy, done;
    logic [63:0] product;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    int          lat_q[$];
    logic [63:0] last_exp = '0;

`ifdef BOOTH_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    always #5 clk = ~clk;

    booth_mul_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .flush        (flush),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    // Digits needed: smallest n such that Q[31:2n-1] are all equal.
    function automatic int exp_lat(input logic [31:0] q);
        logic [31:0] r;
        if (EARLY)
            for (int n = 1; n < 16; n++) begin
                r = $signed(q) >>> (2 * n - 1);
                if (r == 32'd0 || r == 32'hFFFF_FFFF) return n;
            end
        return 16;
    endfunction

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back(ref_mul(a, b));
        lat_q.push_back(exp_lat(b));
    endtask

    task automatic issue_now(input logic [31:0] a, input logic [31:0] b);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        issue_now(a, b);
    endtask

    // cyc = edges after the start edge until done is seen; bc = busy cycles seen.
    task automatic wait_done(output int cyc, output int bc, output bit ok);
        cyc = 0;
        bc  = 0;
        ok  = 1'b0;
        while (cyc <= 40 && !ok) begin
            if (busy) bc++;
            if (done) ok = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b product=%h want 0 0 0", busy, done, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_small();
        int cyc, bc, l;
        bit ok;
        logic [63:0] e;
        push(32'd3, 32'd5);
        issue(32'd3, 32'd5);
        wait_done(cyc, bc, ok);
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        vectors++;
        if (!ok || product !== 64'd15 || e !== 64'd15) begin
            miscompares++;
            $display("FAIL m3q5 product: got %h want %h (done seen %b)", product, 64'd15, ok);
        end
        vectors++;
        if (cyc !== (EARLY ? 2 : 16) || cyc !== l) begin
            miscompares++;
            $display("FAIL m3q5 latency: got %0d want %0d", cyc, l);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done pulse width: done=%b one cycle later, want 0", done);
        end
        last_exp = e;
    endtask

    task automatic test_signed();
        logic [31:0] ta [3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] tb [3] = '{32'd6,         32'h8000_0000, 32'hFFFF_FFFF};
        logic [63:0] tp [3] = '{64'hFFFF_FFFF_FFFF_FFD6, 64'h4000_0000_0000_0000,
                                64'hFFFF_FFFF_8000_0001};
        int cyc, bc, l;
        bit ok;
        logic [63:0] e;
        for (int i = 0; i < 3; i++) begin
            push(ta[i], tb[i]);
            issue(ta[i], tb[i]);
            wait_done(cyc, bc, ok);
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            vectors++;
            if (!ok || product !== tp[i] || e !== tp[i]) begin
                miscompares++;
                $display("FAIL signed[%0d] product: got %h want %h", i, product, tp[i]);
            end
            vectors++;
            if (bc !== l || cyc !== l) begin
                miscompares++;
                $display("FAIL signed[%0d] busy/latency: busy %0d lat %0d want %0d", i, bc, cyc, l);
            end
            last_exp = e;
        end
    endtask

    task automatic test_flush();
        int cyc, bc, l, dones;
        bit ok;
        logic [63:0] e;
        issue(32'h0000_1234, 32'h7FFF_5678);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== last_exp) begin
            miscompares++;
            $display("FAIL flush: busy=%b done=%b product=%h want 0 0 %h", busy, done, product, last_exp);
        end
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL flush no-done: got %0d done pulses want 0", dones);
        end
        push(32'd2, 32'd3);
        issue(32'd2, 32'd3);
        wait_done(cyc, bc, ok);
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        vectors++;
        if (!ok || product !== 64'd6 || cyc !== l) begin
            miscompares++;
            $display("FAIL after-flush 2x3: got %h lat %0d want %h lat %0d", product, cyc, e, l);
        end
        last_exp = e;
    endtask

    task automatic test_back_to_back();
        int cyc, bc, l;
        bit ok;
        logic [63:0] e;
        push(32'h1357_9BDF, 32'h9ABC_DEF1);
        issue(32'h1357_9BDF, 32'h9ABC_DEF1);
        repeat (3) @(negedge clk);
        multiplicand = 32'd11;
        multiplier   = 32'd13;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        wait_done(cyc, bc, ok);
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        vectors++;
        if (!ok || product !== e) begin
            miscompares++;
            $display("FAIL ignored-start product: got %h want %h", product, e);
        end
        vectors++;
        if (cyc + 4 !== l) begin
            miscompares++;
            $display("FAIL ignored-start latency: got %0d want %0d", cyc + 4, l);
        end
        push(32'hFFFF_FF00, 32'h0000_0100);
        issue_now(32'hFFFF_FF00, 32'h0000_0100);
        wait_done(cyc, bc, ok);
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        vectors++;
        if (!ok || product !== 64'hFFFF_FFFF_FFFF_0000 || cyc !== l) begin
            miscompares++;
            $display("FAIL back-to-back: got %h lat %0d want %h lat %0d", product, cyc, e, l);
        end
        last_exp = e;
    endtask

    task automatic test_async_reset();
        issue(32'h0F0F_0F0F, 32'h7654_3210);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
            miscompares++;
            $display("FAIL async reset: busy=%b done=%b product=%h want 0 0 0", busy, done, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int cyc, bc, l;
        bit ok;
        logic [63:0] e;
        logic [31:0] a, b;
        for (int i = 0; i < 500; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) b = {{28{b[3]}}, b[3:0]};
            if (i % 7 == 0) a = {{24{a[7]}}, a[7:0]};
            push(a, b);
            issue(a, b);
            wait_done(cyc, bc, ok);
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            vectors++;
            if (!ok || product !== e || cyc !== l) begin
                miscompares++;
                $display("FAIL random[%0d] %h*%h: got %h lat %0d want %h lat %0d",
                         i, a, b, product, cyc, e, l);
            end
        end
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: %0d left want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_small();
        test_signed();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/booth_mul_sequencer.md
# booth_mul_sequencer

Sequential signed radix-4 (bit-pair recoded Booth) multiplier for the CPU's MUL path. Consumes one recoded multiplier digit per clock, accumulates sign-extended partial products into a 2·WIDTH product, and returns the result to the HI/LO write-back logic with a start/busy/done handshake. The ALU issues one multiply at a time; the block may be flushed on an exception.

## Interface
- WIDTH, 32, operand width; must be even and ≥ 4
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- flush  in  1  synchronous abort of an in-flight multiply
- multiplicand  in  WIDTH  signed operand M, sampled with start
- multiplier  in  WIDTH  signed operand Q, sampled with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; product valid
- product  out  2·WIDTH  signed M·Q, held until the next completion

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; busy=0, done=0, product=0, all internal registers 0.
- IDLE/DONE with start=1: latch M, Q into registers; acc←0; lookback←0; step←0; go RUN. DONE always leaves after one cycle, to RUN if start=1, otherwise to IDLE.
- RUN, each edge: digit = {Q[1], Q[0], lookback}. 000/111→0; 001/010→+M; 011→+2M; 100→−2M; 101/110→−M. Partial product formed at WIDTH+2 bits (no overflow on ±2M), sign-extended to 2·WIDTH, shifted left by 2·step, added to acc modulo 2^(2·WIDTH). Then lookback←Q[1]; Q←Q>>>2 (arithmetic); step←step+1.
- RUN exit: after the step with step=WIDTH/2−1, go DONE and load product←acc (new value).
- flush=1 in RUN: return to IDLE at that edge; acc discarded; product unchanged; no done. flush has priority over completion. flush outside RUN is ignored.
- start while busy=1 is ignored (no queuing); operands must not be assumed stable after the sampling edge.
- Reset asserted mid-operation: immediate return to reset values, including product=0.

## Timing
- Edge E0 samples start. Edges E1..E(WIDTH/2) perform digits 0..WIDTH/2−1.
- busy high from after E0 to after E(WIDTH/2): WIDTH/2 cycles (16 at WIDTH=32).
- done high for exactly one cycle after E(WIDTH/2); product valid from that cycle.
- Back-to-back: start in the done cycle is accepted; throughput one multiply per WIDTH/2+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- BOOTH_EARLY_EXIT_EN defined: at each RUN edge, if after the shift all remaining Q bits and lookback are equal (all-0 or all-1), every remaining digit is zero; go DONE at that edge with product←acc. Latency = number of digits actually needed (minimum 1). The WIDTH/2 bound still applies.
- Undefined: fixed WIDTH/2-cycle latency regardless of operand values.

## Structure
- Shared package: state encoding (IDLE/RUN/DONE), digit-select encoding (ZERO, POS1, POS2, NEG1, NEG2), and the WIDTH/2 step-count constant and its counter width.
- One sub-module: booth_pp_select, combinational; maps the 3-bit digit and M to a WIDTH+2-bit signed partial product. The FSM, counter, shifter and accumulator live in the top module.

## Test plan
- M=3, Q=5 → product 15, done exactly 16 cycles after the start edge (EARLY_EXIT_EN: 2 cycles).
- M=−7, Q=6 → product 0xFFFFFFFF_FFFFFFD6; busy high for 16 cycles.
- M=0x80000000, Q=0x80000000 → 0x40000000_00000000; M=0x7FFFFFFF, Q=0xFFFFFFFF → 0xFFFFFFFF_80000001.
- flush in RUN cycle 5 → IDLE at the next edge, no done, product retains its previous value; a following start 2×3 → 6.
- start pulsed while busy with different operands → ignored; the original result is returned. A start in the done cycle is accepted back-to-back.
- rst_n low mid-RUN → busy=0, done=0, product=0 immediately (asynchronous); 500 random signed pairs compared against a reference model, with and without the macro.
